// File: rtl/timekeeper_pkg.sv
// -----------------------------------------------------------------------------
// timekeeper_pkg
// Shared declarations for the time-of-day engine:
//   - tk_state_e : ring/snooze/dismiss state machine encoding
//   - HR_MAX     : last valid hour value (23)
//   - MS_MAX     : last valid minute/second value (59)
//   - idx_w()    : width of an alarm-channel index, never less than 1 bit
// -----------------------------------------------------------------------------
package timekeeper_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZED  = 2'd2
    } tk_state_e;

    localparam logic [4:0] HR_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the system clock down to a one-second tick.
//   clk   : system clock
//   rst_n : asynchronous reset, active low
//   en    : count enable; the count holds while low
//   clr   : synchronous clear to 0, overrides en
//   tick  : high for the single cycle in which the count sits at CLK_HZ-1
//           while enabled; the count wraps to 0 on the following edge
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_HZ = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (CLK_HZ <= 2) ? 1 : $clog2(CLK_HZ);
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

    logic [CW-1:0] r_cnt;

    assign tick = en && !clr && (r_cnt == TERM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/timekeeper_core.sv
// -----------------------------------------------------------------------------
// timekeeper_core
// Binary hh:mm:ss counter with a direct-set interface, a bank of NUM_ALARMS
// hour/minute alarms and a ring / snooze / dismiss state machine.
//   clk, rst_n       : clock, asynchronous active-low reset
//   run              : count enable
//   set_en           : setting mode; freezes counting and clears the prescaler
//   set_field/set_inc: 0 hour+1, 1 minute+1, 2 seconds clear, 3 no-op
//   al_wr/al_idx/al_hr/al_min/al_en : alarm channel write port
//   dismiss, snooze  : user pulses for the ring state machine
//   hours/minutes/seconds : current time
//   sec_tick         : one-cycle pulse in the cycle before each count step
//   beep             : high while RINGING
//   ring_idx         : channel that caused the current ring
//   snoozing         : high while SNOOZED
//   wr_err           : one-cycle pulse the cycle after a rejected alarm write
// -----------------------------------------------------------------------------
module timekeeper_core
    import timekeeper_pkg::*;
#(
    parameter  int CLK_HZ     = 10000,
    parameter  int NUM_ALARMS = 4,
    parameter  int BEEP_SEC   = 30,
    parameter  int SNOOZE_MIN = 5,
    localparam int IDX_W      = idx_w(NUM_ALARMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             set_en,
    input  logic [1:0]       set_field,
    input  logic             set_inc,
    input  logic             al_wr,
    input  logic [IDX_W-1:0] al_idx,
    input  logic [4:0]       al_hr,
    input  logic [5:0]       al_min,
    input  logic             al_en,
    input  logic             dismiss,
    input  logic             snooze,
    output logic [4:0]       hours,
    output logic [5:0]       minutes,
    output logic [5:0]       seconds,
    output logic             sec_tick,
    output logic             beep,
    output logic [IDX_W-1:0] ring_idx,
    output logic             snoozing,
    output logic             wr_err
);

    localparam logic [7:0]  BEEP_LD  = 8'(BEEP_SEC);
    localparam logic [5:0]  SNZ_LD   = 6'(SNOOZE_MIN);
    localparam logic [31:0] NUM_U    = 32'(NUM_ALARMS);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic w_tick;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run && !set_en),
        .clr   (set_en),
        .tick  (w_tick)
    );

    assign sec_tick = w_tick;

    // ------------------------------------------------------------------
    // Time-of-day counter
    // ------------------------------------------------------------------
    logic [4:0] r_hr;
    logic [5:0] r_min;
    logic [5:0] r_sec;

    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic [4:0] w_hr_nxt;
    logic [5:0] w_min_nxt;
    logic [5:0] w_sec_nxt;
    logic       w_rollover;

    assign w_sec_wrap = (r_sec == MS_MAX);
    assign w_min_wrap = (r_min == MS_MAX);
    assign w_sec_nxt  = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
    assign w_min_nxt  = !w_sec_wrap ? r_min : (w_min_wrap ? 6'd0 : r_min + 6'd1);
    assign w_hr_nxt   = !(w_sec_wrap && w_min_wrap) ? r_hr :
                        ((r_hr == HR_MAX) ? 5'd0 : r_hr + 5'd1);

    // Counted transition into seconds == 0; the only moment alarms are compared
    // and the only event that ages the snooze counter.
    assign w_rollover = w_tick && w_sec_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hr  <= '0;
            r_min <= '0;
            r_sec <= '0;
        end else if (w_tick) begin
            r_hr  <= w_hr_nxt;
            r_min <= w_min_nxt;
            r_sec <= w_sec_nxt;
        end else if (set_en && set_inc) begin
            // Setting adjusts one field in isolation; nothing carries.
            case (set_field)
                2'd0:    r_hr  <= (r_hr == HR_MAX) ? 5'd0 : r_hr + 5'd1;
                2'd1:    r_min <= (r_min == MS_MAX) ? 6'd0 : r_min + 6'd1;
                2'd2:    r_sec <= 6'd0;
                default: ;
            endcase
        end
    end

    assign hours   = r_hr;
    assign minutes = r_min;
    assign seconds = r_sec;

    // ------------------------------------------------------------------
    // Alarm bank
    // ------------------------------------------------------------------
    logic [4:0] r_al_hr  [NUM_ALARMS];
    logic [5:0] r_al_min [NUM_ALARMS];
    logic       r_al_en  [NUM_ALARMS];
    logic       r_wr_err;

    logic       w_wr_ok;

    assign w_wr_ok = (al_hr <= HR_MAX) && (al_min <= MS_MAX) && (32'(al_idx) < NUM_U);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                r_al_hr[i]  <= '0;
                r_al_min[i] <= '0;
                r_al_en[i]  <= 1'b0;
            end
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= al_wr && !w_wr_ok;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (al_wr && w_wr_ok && (al_idx == IDX_W'(i))) begin
                    r_al_hr[i]  <= al_hr;
                    r_al_min[i] <= al_min;
                    r_al_en[i]  <= al_en;
                end
            end
        end
    end

    assign wr_err = r_wr_err;

    // Compare against the time about to be loaded. Scanning from the top
    // index down leaves the lowest hitting channel in w_hit_idx.
    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_hit_ev;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (r_al_en[i] && (r_al_hr[i] == w_hr_nxt) && (r_al_min[i] == w_min_nxt)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_hit_ev = w_rollover && w_hit;

    // ------------------------------------------------------------------
    // Ring / snooze state machine
    // ------------------------------------------------------------------
    tk_state_e        r_state;
    tk_state_e        w_state_nxt;
    logic [7:0]       r_beep_cnt;
    logic [7:0]       w_beep_nxt;
    logic [5:0]       r_snz_cnt;
    logic [5:0]       w_snz_nxt;
    logic [IDX_W-1:0] r_ring_idx;
    logic [IDX_W-1:0] w_ring_idx_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_beep_cnt <= '0;
            r_snz_cnt  <= '0;
            r_ring_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_beep_cnt <= w_beep_nxt;
            r_snz_cnt  <= w_snz_nxt;
            r_ring_idx <= w_ring_idx_nxt;
        end
    end

    // Priority inside each state: new hit, then dismiss, then snooze, then
    // counter expiry.
    always_comb begin
        w_state_nxt    = r_state;
        w_beep_nxt     = r_beep_cnt;
        w_snz_nxt      = r_snz_cnt;
        w_ring_idx_nxt = r_ring_idx;
        case (r_state)
            IDLE: begin
                if (w_hit_ev) begin
                    w_state_nxt    = RINGING;
                    w_beep_nxt     = BEEP_LD;
                    w_ring_idx_nxt = w_hit_idx;
                end
            end
            RINGING: begin
                if (w_hit_ev) begin
                    w_beep_nxt     = BEEP_LD;
                    w_ring_idx_nxt = w_hit_idx;
                end else if (dismiss) begin
                    w_state_nxt = IDLE;
                end else if (snooze) begin
                    w_state_nxt = SNOOZED;
                    w_snz_nxt   = SNZ_LD;
                end else if (w_tick) begin
                    if (r_beep_cnt <= 8'd1) begin
                        w_state_nxt = IDLE;
                        w_beep_nxt  = 8'd0;
                    end else begin
                        w_beep_nxt  = r_beep_cnt - 8'd1;
                    end
                end
            end
            SNOOZED: begin
                if (w_hit_ev) begin
                    w_state_nxt    = RINGING;
                    w_beep_nxt     = BEEP_LD;
                    w_ring_idx_nxt = w_hit_idx;
                end else if (dismiss) begin
                    w_state_nxt = IDLE;
                end else if (w_rollover) begin
                    if (r_snz_cnt <= 6'd1) begin
                        w_state_nxt = RINGING;
                        w_beep_nxt  = BEEP_LD;
                        w_snz_nxt   = 6'd0;
                    end else begin
                        w_snz_nxt   = r_snz_cnt - 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign beep     = (r_state == RINGING);
    assign snoozing = (r_state == SNOOZED);
    assign ring_idx = r_ring_idx;

endmodule

// File: tb/tb_timekeeper_core.sv
// Scoreboard bench for timekeeper_core with CLK_HZ=10, NUM_ALARMS=3,
// BEEP_SEC=3, SNOOZE_MIN=2. Stimulus pushes expected observable state into a
// queue; the monitor pops and compares on the following falling edge.
// A second monitor pops an expected-error queue whenever wr_err is seen high.
module tb_timekeeper_core;

    localparam int CLK_HZ     = 10;
    localparam int NUM_ALARMS = 3;
    localparam int BEEP_SEC   = 3;
    localparam int SNOOZE_MIN = 2;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       tick;
        logic       beep;
        logic       snz;
        logic [1:0] idx;
        logic       werr;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       set_en;
    logic [1:0] set_field;
    logic       set_inc;
    logic       al_wr;
    logic [1:0] al_idx;
    logic [4:0] al_hr;
    logic [5:0] al_min;
    logic       al_en;
    logic       dismiss;
    logic       snooze;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sec_tick;
    logic       beep;
    logic [1:0] ring_idx;
    logic       snoozing;
    logic       wr_err;

    int n_vec = 0;
    int n_bad = 0;

    obs_t  exp_q  [$];
    string name_q [$];
    int    err_q  [$];

    always #5 clk = ~clk;

    timekeeper_core #(
        .CLK_HZ     (CLK_HZ),
        .NUM_ALARMS (NUM_ALARMS),
        .BEEP_SEC   (BEEP_SEC),
        .SNOOZE_MIN (SNOOZE_MIN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .set_en    (set_en),
        .set_field (set_field),
        .set_inc   (set_inc),
        .al_wr     (al_wr),
        .al_idx    (al_idx),
        .al_hr     (al_hr),
        .al_min    (al_min),
        .al_en     (al_en),
        .dismiss   (dismiss),
        .snooze    (snooze),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .sec_tick  (sec_tick),
        .beep      (beep),
        .ring_idx  (ring_idx),
        .snoozing  (snoozing),
        .wr_err    (wr_err)
    );

    function automatic string fmt(input obs_t o);
        return $sformatf("%0d:%0d:%0d tick=%0b beep=%0b snz=%0b idx=%0d werr=%0b",
                         o.h, o.m, o.s, o.tick, o.beep, o.snz, o.idx, o.werr);
    endfunction

    // State monitor
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string nm;
        while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {hours, minutes, seconds, sec_tick, beep, snoozing, ring_idx, wr_err};
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got %s, want %s", nm, fmt(a), fmt(e));
            end
        end
    end

    // Error-pulse monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_err === 1'b1) begin
            n_vec++;
            if (err_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_err_unexpected: got wr_err=1, want 0 at %0t", $time);
            end else begin
                void'(err_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input int h, input int m, input int s,
                             input logic tk, input logic bp, input logic sz,
                             input int idx, input logic we);
        obs_t e;
        e.h    = 5'(h);
        e.m    = 6'(m);
        e.s    = 6'(s);
        e.tick = tk;
        e.beep = bp;
        e.snz  = sz;
        e.idx  = 2'(idx);
        e.werr = we;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic set_pulse(input int field, input int n);
        for (int k = 0; k < n; k++) begin
            set_field = 2'(field);
            set_inc   = 1'b1;
            cyc(1);
            set_inc   = 1'b0;
        end
    endtask

    task automatic alarm_write(input int idx, input int h, input int m, input logic en);
        al_idx = 2'(idx);
        al_hr  = 5'(h);
        al_min = 6'(m);
        al_en  = en;
        al_wr  = 1'b1;
        cyc(1);
        al_wr  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; run = 1'b1; set_en = 1'b0; set_field = 2'd3; set_inc = 1'b0;
        al_wr = 1'b0; al_idx = '0; al_hr = '0; al_min = '0; al_en = 1'b0;
        dismiss = 1'b0; snooze = 1'b0;

        // Reset state
        @(posedge clk); #1;
        expect_st("reset_state", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Free-running count
        cyc(9);
        expect_st("first_tick", 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(1);
        expect_st("first_second", 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(5990);
        expect_st("600_ticks", 0, 10, 0, 0, 0, 0, 0, 0);

        // Setting mode
        cyc(35);
        set_en = 1'b1;
        cyc(1);
        expect_st("set_freeze", 0, 10, 3, 0, 0, 0, 0, 0);
        set_pulse(0, 24);
        expect_st("set_hour_wrap", 0, 10, 3, 0, 0, 0, 0, 0);
        set_pulse(0, 23);
        set_pulse(1, 50);
        expect_st("set_min_wrap_nocarry", 23, 0, 3, 0, 0, 0, 0, 0);
        set_pulse(1, 59);
        set_pulse(2, 1);
        expect_st("set_sec_clear", 23, 59, 0, 0, 0, 0, 0, 0);
        set_pulse(3, 1);
        expect_st("set_noop", 23, 59, 0, 0, 0, 0, 0, 0);
        set_en    = 1'b0;
        set_field = 2'd0;
        set_inc   = 1'b1;
        cyc(1);
        set_inc   = 1'b0;
        cyc(579);
        expect_st("inc_ignored_2359_58", 23, 59, 58, 0, 0, 0, 0, 0);
        cyc(10);
        expect_st("at_23_59_59", 23, 59, 59, 0, 0, 0, 0, 0);
        cyc(10);
        expect_st("day_rollover", 0, 0, 0, 0, 0, 0, 0, 0);

        // Alarm hit with priority, then auto-stop
        alarm_write(0, 0, 1, 1'b1);
        alarm_write(2, 0, 1, 1'b1);
        cyc(597);
        expect_st("pre_alarm", 0, 0, 59, 1, 0, 0, 0, 0);
        cyc(1);
        expect_st("alarm_ring_lowest", 0, 1, 0, 0, 1, 0, 0, 0);
        cyc(29);
        expect_st("ring_before_expiry", 0, 1, 2, 1, 1, 0, 0, 0);
        cyc(1);
        expect_st("ring_expired", 0, 1, 3, 0, 0, 0, 0, 0);

        // Snooze and re-ring, then dismiss beats snooze
        alarm_write(1, 0, 2, 1'b1);
        cyc(569);
        expect_st("alarm1_ring", 0, 2, 0, 0, 1, 0, 1, 0);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        expect_st("snoozed", 0, 2, 0, 0, 0, 1, 1, 0);
        cyc(1198);
        expect_st("still_snoozed", 0, 3, 59, 1, 0, 1, 1, 0);
        cyc(1);
        expect_st("snooze_reringing", 0, 4, 0, 0, 1, 0, 1, 0);
        dismiss = 1'b1;
        snooze  = 1'b1;
        cyc(1);
        dismiss = 1'b0;
        snooze  = 1'b0;
        expect_st("dismiss_wins", 0, 4, 0, 0, 0, 0, 1, 0);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        expect_st("snooze_idle_ignored", 0, 4, 0, 0, 0, 0, 1, 0);

        // Alarm write rejection
        alarm_write(1, 0, 5, 1'b1);
        err_q.push_back(1);
        alarm_write(1, 24, 5, 1'b1);
        expect_st("wr_err_hr24", 0, 4, 0, 0, 0, 0, 1, 1);
        err_q.push_back(2);
        alarm_write(1, 0, 60, 1'b1);
        expect_st("wr_err_min60", 0, 4, 0, 0, 0, 0, 1, 1);
        err_q.push_back(3);
        alarm_write(3, 0, 6, 1'b1);
        expect_st("wr_err_idx", 0, 4, 0, 0, 0, 0, 1, 1);
        cyc(1);
        expect_st("wr_err_clear", 0, 4, 0, 0, 0, 0, 1, 0);
        cyc(592);
        expect_st("pre_alarm1_0005", 0, 4, 59, 1, 0, 0, 1, 0);
        cyc(1);
        expect_st("channel_unchanged_ring", 0, 5, 0, 0, 1, 0, 1, 0);

        // Reset mid-ring and mid-second
        cyc(4);
        rst_n = 1'b0;
        expect_st("reset_mid_ring", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(2);
        rst_n = 1'b1;
        expect_st("after_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(599);
        expect_st("post_reset_restart", 0, 0, 59, 1, 0, 0, 0, 0);
        cyc(1);
        expect_st("alarms_disabled", 0, 1, 0, 0, 0, 0, 0, 0);

        cyc(2);
        n_vec++;
        if (err_q.size() != 0) begin
            n_bad++;
            $display("FAIL wr_err_missing: got %0d pending, want 0", err_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
